// File: rtl/idli_alu_slice_if.sv
// idli_alu_slice_if: shared slice types and the operand/result bus of the serial ALU stage.
package idli_pkg;
    typedef logic [1:0] ctr_t;
    typedef logic [3:0] slice_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;
    typedef enum logic [1:0] {CMP_EQ, CMP_NE, CMP_LT, CMP_GE} cmp_op_t;
endpackage

interface idli_alu_slice_if;
    import idli_pkg::*;
    logic    i_valid;
    ctr_t    i_ctr;
    alu_op_t i_alu_op;
    logic    i_alu_rhs_inv;
    cmp_op_t i_cmp_op;
    logic    i_cmp_sign;
    logic    i_wr_p;
    slice_t  i_lhs;
    slice_t  i_rhs;
    slice_t  o_res;
    logic    o_res_vld;
    logic    o_p;
    logic    o_p_vld;
    modport master (
        output i_valid, i_ctr, i_alu_op, i_alu_rhs_inv, i_cmp_op, i_cmp_sign, i_wr_p, i_lhs, i_rhs,
        input  o_res, o_res_vld, o_p, o_p_vld
    );
    modport slave (
        input  i_valid, i_ctr, i_alu_op, i_alu_rhs_inv, i_cmp_op, i_cmp_sign, i_wr_p, i_lhs, i_rhs,
        output o_res, o_res_vld, o_p, o_p_vld
    );
endinterface

// File: rtl/idli_alu_slice.sv
// idli_alu_slice: 4-bit slice-serial ALU execute stage, LSB slice first, four slices per instruction.
// Compare/predicate logic is present only when IDLI_ALU_CMP_EN is defined.
module idli_alu_slice
    import idli_pkg::*;
(
    input logic i_clk,
    input logic i_rst_n,
    idli_alu_slice_if.slave bus
);
    ctr_t   exp_ctr;
    logic   carry;
    slice_t rhs_x;
    slice_t sum;
    slice_t res;
    logic   cin;
    logic   cout;
    logic   accept;

    always_comb begin
        rhs_x = bus.i_rhs ^ {4{bus.i_alu_rhs_inv}};
        cin = (bus.i_ctr == 2'd0) ? bus.i_alu_rhs_inv : carry;
        {cout, sum} = {1'b0, bus.i_lhs} + {1'b0, rhs_x} + {4'd0, cin};
        res = (bus.i_alu_op == ALU_ADD) ? sum :
              (bus.i_alu_op == ALU_AND) ? (bus.i_lhs & rhs_x) :
              (bus.i_alu_op == ALU_OR)  ? (bus.i_lhs | rhs_x) : (bus.i_lhs ^ rhs_x);
        // slice 0 always restarts; any other out-of-order slice is dropped
        accept = bus.i_valid && (bus.i_ctr == 2'd0 || bus.i_ctr == exp_ctr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_ctr       <= 2'd0;
            carry         <= 1'b0;
            bus.o_res     <= 4'd0;
            bus.o_res_vld <= 1'b0;
        end else begin
            bus.o_res_vld <= accept;
            exp_ctr       <= accept ? bus.i_ctr + 2'd1 : 2'd0;
            if (accept) begin
                bus.o_res <= res;
                carry     <= (bus.i_alu_op == ALU_ADD) ? cout : 1'b0;
            end
        end
    end

`ifdef IDLI_ALU_CMP_EN
    logic zacc;
    logic zacc_n;
    logic lt;
    logic p;

    always_comb begin
        zacc_n = (bus.i_ctr == 2'd0 || zacc) && (sum == 4'd0);
        lt = bus.i_cmp_sign ? (sum[3] ^ ((bus.i_lhs[3] == rhs_x[3]) && (sum[3] != bus.i_lhs[3]))) : !cout;
        p = (bus.i_cmp_op == CMP_EQ) ? zacc_n :
            (bus.i_cmp_op == CMP_NE) ? !zacc_n :
            (bus.i_cmp_op == CMP_LT) ? lt : !lt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            zacc        <= 1'b1;
            bus.o_p     <= 1'b0;
            bus.o_p_vld <= 1'b0;
        end else begin
            bus.o_p_vld <= accept && bus.i_ctr == 2'd3 && bus.i_wr_p;
            if (accept)
                zacc <= zacc_n;
            if (accept && bus.i_ctr == 2'd3 && bus.i_wr_p)
                bus.o_p <= p;
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = ^{bus.i_cmp_op, bus.i_cmp_sign, bus.i_wr_p};
    assign bus.o_p = 1'b0;
    assign bus.o_p_vld = 1'b0;
`endif
endmodule

// File: tb/tb_idli_alu_slice.sv
// tb_idli_alu_slice: directed-vector bench for the slice-serial ALU, covering both macro builds.
module tb_idli_alu_slice;
    import idli_pkg::*;

`ifdef IDLI_ALU_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic p_hold = 1'b0;

    idli_alu_slice_if bus ();

    idli_alu_slice dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input alu_op_t op, input logic inv, input cmp_op_t cmp, input logic sign,
                         input logic wrp, input logic [1:0] ctr, input logic [3:0] a, input logic [3:0] b);
        bus.i_valid = 1'b1;
        bus.i_alu_op = op;
        bus.i_alu_rhs_inv = inv;
        bus.i_cmp_op = cmp;
        bus.i_cmp_sign = sign;
        bus.i_wr_p = wrp;
        bus.i_ctr = ctr;
        bus.i_lhs = a;
        bus.i_rhs = b;
    endtask

    // full four-slice instruction; result and predicate checked one cycle after each slice
    task automatic run_op(input string tag, input alu_op_t op, input logic inv, input cmp_op_t cmp,
                          input logic sign, input logic wrp, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r, input logic p);
        for (int i = 0; i < 4; i++) begin
            drive(op, inv, cmp, sign, wrp, 2'(i), a[4*i +: 4], b[4*i +: 4]);
            @(negedge clk);
            check({tag, "_res"}, 16'(bus.o_res), 16'(r[4*i +: 4]));
            check({tag, "_vld"}, 16'(bus.o_res_vld), 16'd1);
            if (i == 3 && CMP && wrp) begin
                p_hold = p;
                check({tag, "_pvld"}, 16'(bus.o_p_vld), 16'd1);
            end else begin
                check({tag, "_pvld0"}, 16'(bus.o_p_vld), 16'd0);
            end
            check({tag, "_p"}, 16'(bus.o_p), 16'(p_hold));
        end
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        drive(ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
        bus.i_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_res", 16'(bus.o_res), 16'd0);
        check("rst_vld", 16'(bus.o_res_vld), 16'd0);
        check("rst_p", 16'(bus.o_p), 16'd0);
        check("rst_pvld", 16'(bus.o_p_vld), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sub_lt", ALU_ADD, 1'b1, CMP_LT, 1'b0, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b1);
        run_op("carry", ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0);
        run_op("sub_ge", ALU_ADD, 1'b1, CMP_LT, 1'b0, 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b0);
        run_op("slt_s", ALU_ADD, 1'b1, CMP_LT, 1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
        run_op("slt_u", ALU_ADD, 1'b1, CMP_LT, 1'b0, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
        run_op("ge_s", ALU_ADD, 1'b1, CMP_GE, 1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
        run_op("eq1", ALU_ADD, 1'b1, CMP_EQ, 1'b0, 1'b1, 16'hABCD, 16'hABCD, 16'h0000, 1'b1);
        run_op("ne0", ALU_ADD, 1'b1, CMP_NE, 1'b0, 1'b1, 16'hABCD, 16'hABCD, 16'h0000, 1'b0);
        run_op("eq0", ALU_ADD, 1'b1, CMP_EQ, 1'b0, 1'b1, 16'hABCD, 16'hABCC, 16'h0001, 1'b0);
        run_op("ne1", ALU_ADD, 1'b1, CMP_NE, 1'b0, 1'b1, 16'hABCD, 16'hABCC, 16'h0001, 1'b1);
        run_op("xor", ALU_XOR, 1'b0, CMP_EQ, 1'b0, 1'b0, 16'hA5C3, 16'h0FF0, 16'hAA33, 1'b0);
        run_op("or", ALU_OR, 1'b0, CMP_EQ, 1'b0, 1'b0, 16'h1200, 16'h0034, 16'h1234, 1'b0);
        idle();

        // abort after two slices leaving a live carry, then a clean AND
        drive(ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b1, 2'd0, 4'hF, 4'h1);
        @(negedge clk);
        drive(ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b1, 2'd1, 4'hF, 4'h0);
        @(negedge clk);
        check("abort_s1", 16'(bus.o_res), 16'h0);
        idle();
        check("abort_vld", 16'(bus.o_res_vld), 16'd0);
        check("abort_pvld", 16'(bus.o_p_vld), 16'd0);
        run_op("and", ALU_AND, 1'b0, CMP_EQ, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0);
        run_op("add_nc", ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0);
        idle();

        // out-of-order slices are dropped and re-arm the counter to 0
        drive(ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b0, 2'd2, 4'h7, 4'h1);
        @(negedge clk);
        check("drop_vld", 16'(bus.o_res_vld), 16'd0);
        check("drop_hold", 16'(bus.o_res), 16'h0);
        drive(ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b0, 2'd1, 4'h7, 4'h1);
        @(negedge clk);
        check("drop2_vld", 16'(bus.o_res_vld), 16'd0);
        run_op("after_drop", ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b0, 16'h0F0F, 16'h0101, 16'h1010, 1'b0);

        // set o_p, then reset mid-ADD
        run_op("pre_rst", ALU_ADD, 1'b1, CMP_EQ, 1'b0, 1'b1, 16'h1111, 16'h1111, 16'h0000, 1'b1);
        drive(ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b0, 2'd0, 4'h4, 4'hF);
        @(negedge clk);
        check("mid_res", 16'(bus.o_res), 16'h3);
        drive(ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b0, 2'd1, 4'h3, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res", 16'(bus.o_res), 16'd0);
        check("arst_vld", 16'(bus.o_res_vld), 16'd0);
        check("arst_p", 16'(bus.o_p), 16'd0);
        check("arst_pvld", 16'(bus.o_p_vld), 16'd0);
        p_hold = 1'b0;
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // a slice 1 right after release must not be accepted
        drive(ALU_ADD, 1'b0, CMP_EQ, 1'b0, 1'b0, 2'd1, 4'h3, 4'hF);
        @(negedge clk);
        check("post_rst_drop", 16'(bus.o_res_vld), 16'd0);
        run_op("b2b_a", ALU_ADD, 1'b1, CMP_EQ, 1'b0, 1'b1, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b1);
        run_op("b2b_b", ALU_ADD, 1'b1, CMP_EQ, 1'b0, 1'b1, 16'h5A5A, 16'h5A5B, 16'hFFFF, 1'b0);
        idle();
        check("tail_pvld", 16'(bus.o_p_vld), 16'd0);
        check("tail_vld", 16'(bus.o_res_vld), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/idli_alu_slice.md
# idli_alu_slice

Slice-serial execute stage for the ALU pipe. It consumes the decoded operation fields and one 4b operand slice per cycle for four consecutive cycles, least-significant slice first, and produces one registered result slice per cycle. Between slices it carries the add carry and the compare state, and at the end of the instruction it generates the predicate write. It sits directly downstream of the decoder's operation output and feeds the destination writeback mux (register, PC, SQI or UART).

## Interface
Parameters: none; all widths come from the shared package types.

Ports:
- `i_clk`  in  1  core clock
- `i_rst_n`  in  1  reset; asynchronous assert, active-low
- `i_valid`  in  1  slice inputs valid this cycle
- `i_ctr`  in  2 (`ctr_t`)  slice index, 0 = bits [3:0], 3 = bits [15:12]
- `i_alu_op`  in  2 (`alu_op_t`)  ADD/AND/OR/XOR
- `i_alu_rhs_inv`  in  1  invert RHS; for ADD also forces carry-in 1 at slice 0 (subtract)
- `i_cmp_op`  in  2 (`cmp_op_t`)  EQ/NE/LT/GE
- `i_cmp_sign`  in  1  LT/GE signed when 1
- `i_wr_p`  in  1  instruction writes predicate
- `i_lhs`  in  4 (`slice_t`)  LHS slice
- `i_rhs`  in  4 (`slice_t`)  RHS slice
- `o_res`  out  4 (`slice_t`)  registered result slice
- `o_res_vld`  out  1  `o_res` valid
- `o_p`  out  1  last predicate value (held)
- `o_p_vld`  out  1  one-cycle pulse: `o_p` updated

## Operation
- Operation fields must be held stable across all four slices of an instruction. Fields are sampled at every valid slice.
- RHS operand:
  - `rhs' = i_rhs ^ {4{i_alu_rhs_inv}}`
- ADD:
  - `{cout, sum} = i_lhs + rhs' + cin`, 5b.
  - `cin` is `i_alu_rhs_inv` when `i_ctr==0`; otherwise it is the carry register.
  - The carry register loads `cout` on each valid slice.
- AND/OR/XOR:
  - Bitwise on `i_lhs` and `rhs'`.
  - The carry register is cleared.
- Zero tracking:
  - `zacc` = AND over the slices so far of `(sum==0)`.
  - It is reset by slice 0, which uses its own value without accumulating.
  - It uses the ADD sum regardless of `i_alu_op`. Compares are decoded as ADD with `rhs_inv=1`.
- At slice 3 with `i_wr_p`:
  - EQ = `zacc_final`
  - NE = `!zacc_final`
  - LT unsigned = `!cout`
  - LT signed = `N ^ V`, where `N = sum[3]` and `V = (i_lhs[3]==rhs'[3]) & (sum[3]!=i_lhs[3])`
  - GE = `!LT`
- The result is registered into `o_p` and `o_p_vld` is pulsed.
- Sequencing:
  - An internal expected-index counter advances on each valid slice and wraps 3→0.
  - A valid slice with `i_ctr==0` always starts a new instruction, discarding any partial state.
  - A valid slice whose `i_ctr` ≠ expected, with `i_ctr`≠0, is dropped. Carry, `zacc` and outputs are unchanged, and the counter returns to expecting 0.
  - `i_valid` low mid-instruction aborts: the counter returns to expecting 0, and no predicate is produced for the aborted instruction.
- Back-to-back instructions (slice 3 followed immediately by slice 0) need no bubble.

## Timing
- Reset values:
  - `o_res=0`, `o_res_vld=0`, `o_p=0`, `o_p_vld=0`
  - carry=0, `zacc=1`, expected index=0
- Reset mid-instruction clears all state immediately (asynchronous). The first slice accepted after release must have `ctr==0`.
- Latency:
  - A valid slice accepted in cycle n appears on `o_res` with `o_res_vld=1` in cycle n+1.
  - The predicate for an instruction whose slice 3 is in cycle n appears with `o_p_vld=1` in cycle n+1.
  - `o_p` holds its value until the next predicate write.
- Invalid or dropped cycles:
  - `o_res_vld=0` in the following cycle.
  - `o_res` holds its previous value.
- No backpressure: the downstream stage must accept every `o_res_vld` slice.

## Configuration
- `IDLI_ALU_CMP_EN`
  - Defined: compare logic present (zero tracking, signed/unsigned LT/GE, predicate output).
  - Undefined: `zacc` and compare logic are removed, `o_p` and `o_p_vld` are tied 0, and `i_cmp_op`, `i_cmp_sign` and `i_wr_p` are ignored. ADD/AND/OR/XOR behaviour is identical in both builds.

## Test plan
- **Carry propagation.** ADD 0x1234 + 0x0FFF, slices ctr 0..3 on consecutive cycles.
  - `o_res` = 3,3,2,2 (0x2233) in cycles 1..4, `o_res_vld` high throughout.
  - No `o_p_vld`.
- **Subtract with unsigned LT.** ADD, `rhs_inv=1`, LT unsigned, `wr_p`, 0x0005 vs 0x0007.
  - `o_res` = 0xFFFE (E,F,F,F).
  - `o_p=1` with `o_p_vld` pulse in cycle 4.
  - Repeat 0x0007 vs 0x0005 → `o_p=0`.
- **Signed LT.** 0x8000 vs 0x0001.
  - `cmp_sign=1` → `o_p=1`.
  - `cmp_sign=0` → `o_p=0`.
- **EQ/NE.** 0xABCD vs 0xABCD: EQ → `o_p=1`, NE → `o_p=0`. 0xABCD vs 0xABCC: EQ → `o_p=0`.
- **Abort with no stale carry.**
  - Start ADD 0xFFFF + 0x0001, then drop `i_valid` after ctr 1.
  - Then send AND 0xF0F0 & 0x0FF0: `o_res` = 0x00F0 with no stale carry, and no `o_p_vld` for the aborted op.
  - Send ctr 2 without ctr 0: it is dropped, with `o_res_vld` low.
- **Reset and back-to-back.**
  - Assert `i_rst_n` low mid-ADD: all outputs 0 immediately.
  - After release, two back-to-back CMP EQ instructions give two `o_p_vld` pulses exactly 4 cycles apart.
- **Build without the macro.** Repeat the signed LT scenario without `IDLI_ALU_CMP_EN`: `o_p_vld` stays 0.
